// File: rtl/z80_mem_arbiter_if.sv
// Bus bundle between the tv80 CPU, one DMA requester, the shared RAM port
// and the I/O read path; the arbiter connects through the slave modport.
interface z80_mem_arbiter_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 8
);
    logic              cpu_mreq_n;
    logic              cpu_rd_n;
    logic              cpu_wr_n;
    logic              cpu_iorq_n;
    logic [15:0]       cpu_addr;
    logic [DATA_W-1:0] cpu_dout;
    logic [DATA_W-1:0] cpu_din;
    logic              cpu_wait_n;
    logic [DATA_W-1:0] io_din;
    logic              dma_req;
    logic              dma_we;
    logic [ADDR_W-1:0] dma_addr;
    logic [DATA_W-1:0] dma_wdata;
    logic              dma_gnt;
    logic              dma_ack;
    logic [DATA_W-1:0] dma_rdata;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic [15:0]       stat_dma_cnt;
    logic [15:0]       stat_stall_cnt;

    // Arbiter side
    modport slave (
        input  cpu_mreq_n, cpu_rd_n, cpu_wr_n, cpu_iorq_n, cpu_addr, cpu_dout,
        input  io_din,
        input  dma_req, dma_we, dma_addr, dma_wdata,
        input  mem_rdata,
        output cpu_din, cpu_wait_n,
        output dma_gnt, dma_ack, dma_rdata,
        output mem_we, mem_addr, mem_wdata,
        output stat_dma_cnt, stat_stall_cnt
    );

    // CPU, DMA requester, memory and I/O side
    modport master (
        output cpu_mreq_n, cpu_rd_n, cpu_wr_n, cpu_iorq_n, cpu_addr, cpu_dout,
        output io_din,
        output dma_req, dma_we, dma_addr, dma_wdata,
        output mem_rdata,
        input  cpu_din, cpu_wait_n,
        input  dma_gnt, dma_ack, dma_rdata,
        input  mem_we, mem_addr, mem_wdata,
        input  stat_dma_cnt, stat_stall_cnt
    );
endinterface

// File: rtl/z80_mem_arbiter.sv
// CPU/DMA arbiter for the shared single-port RAM plus the CPU read-data mux.
// Optional statistics counters are built when Z80_MEM_ARBITER_STATS_EN is defined.
module z80_mem_arbiter #(
    parameter int ADDR_W     = 10,
    parameter int DATA_W     = 8,
    parameter int STARVE_LIM = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    z80_mem_arbiter_if.slave  bus
);
    localparam logic [3:0] LIM = 4'(STARVE_LIM);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_ACK  = 1'b1
    } state_t;

    state_t            r_state;
    state_t            w_next_state;
    logic [3:0]        r_starve;
    logic [3:0]        w_starve_nxt;
    logic              r_dma_ack;

    logic              w_cpu_mem;
    logic              w_take_dma;
    logic              w_gnt;
    logic              w_stall;
    logic              w_mem_we;
    logic [ADDR_W-1:0] w_mem_addr;
    logic [DATA_W-1:0] w_mem_wdata;
    logic [DATA_W-1:0] w_dma_rdata;
    logic              w_unused_addr;

    assign w_cpu_mem     = !bus.cpu_mreq_n && (!bus.cpu_rd_n || !bus.cpu_wr_n);
    assign w_unused_addr = ^bus.cpu_addr[15:ADDR_W];

    // Next-state, starvation counter and memory-port steering
    always_comb begin
        w_next_state = r_state;
        w_starve_nxt = r_starve;
        w_take_dma   = 1'b0;
        w_gnt        = 1'b0;
        w_stall      = 1'b0;
        w_mem_we     = w_cpu_mem && !bus.cpu_wr_n;
        w_mem_addr   = bus.cpu_addr[ADDR_W-1:0];
        w_mem_wdata  = bus.cpu_dout;
        w_dma_rdata  = {DATA_W{1'b0}};
        case (r_state)
            ST_IDLE: begin
                w_take_dma = bus.dma_req && (!w_cpu_mem || (r_starve == LIM));
                if (w_take_dma) begin
                    w_gnt        = 1'b1;
                    w_stall      = w_cpu_mem;
                    w_mem_we     = bus.dma_we;
                    w_mem_addr   = bus.dma_addr;
                    w_mem_wdata  = bus.dma_wdata;
                    w_next_state = ST_ACK;
                    w_starve_nxt = 4'd0;
                end else if (bus.dma_req) begin
                    w_starve_nxt = (r_starve == LIM) ? LIM : (r_starve + 4'd1);
                end else begin
                    w_starve_nxt = 4'd0;
                end
            end
            ST_ACK: begin
                // A request already pending here is only looked at in the next IDLE cycle
                w_dma_rdata  = bus.mem_rdata;
                w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
                w_starve_nxt = 4'd0;
            end
        endcase
    end

    // State, starvation count and the registered completion pulse
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= ST_IDLE;
            r_starve  <= 4'd0;
            r_dma_ack <= 1'b0;
        end else begin
            r_state   <= w_next_state;
            r_starve  <= w_starve_nxt;
            r_dma_ack <= w_gnt;
        end
    end

    // Combinational outputs are held at their reset values while reset is low
    assign bus.dma_gnt    = reset_n && w_gnt;
    assign bus.cpu_wait_n = !(reset_n && w_stall);
    assign bus.mem_we     = reset_n && w_mem_we;
    assign bus.mem_addr   = w_mem_addr;
    assign bus.mem_wdata  = w_mem_wdata;
    assign bus.dma_ack    = r_dma_ack;
    assign bus.dma_rdata  = w_dma_rdata;
    assign bus.cpu_din    = (!bus.cpu_iorq_n) ? bus.io_din : bus.mem_rdata;

`ifdef Z80_MEM_ARBITER_STATS_EN
    logic [15:0] r_stat_dma_cnt;
    logic [15:0] r_stat_stall_cnt;

    // Free-running grant and stall counters, wrapping at 16 bits
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_stat_dma_cnt   <= 16'd0;
            r_stat_stall_cnt <= 16'd0;
        end else begin
            if (w_gnt) begin
                r_stat_dma_cnt <= r_stat_dma_cnt + 16'd1;
            end
            if (w_stall) begin
                r_stat_stall_cnt <= r_stat_stall_cnt + 16'd1;
            end
        end
    end

    assign bus.stat_dma_cnt   = r_stat_dma_cnt;
    assign bus.stat_stall_cnt = r_stat_stall_cnt;
`else
    assign bus.stat_dma_cnt   = 16'd0;
    assign bus.stat_stall_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_z80_mem_arbiter.sv
// Self-checking bench for z80_mem_arbiter: CPU vector table, DMA scoreboard,
// starvation, I/O mux, reset-mid-transfer and statistics sequences.
module tb_z80_mem_arbiter;
    logic clk = 1'b0;
    logic reset_n;

    z80_mem_arbiter_if #(.ADDR_W(10), .DATA_W(8)) bus ();

    z80_mem_arbiter #(.ADDR_W(10), .DATA_W(8), .STARVE_LIM(4)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    // Synchronous RAM model: read data one cycle after the address
    logic [7:0] ram [1024];
    always @(posedge clk) begin
        if (bus.mem_we === 1'b1) ram[bus.mem_addr] <= bus.mem_wdata;
        bus.mem_rdata <= ram[bus.mem_addr];
    end

    int n_checks = 0;
    int n_fail   = 0;
    int n_acks   = 0;

    typedef struct {
        logic       chk;
        logic [7:0] data;
    } sb_t;
    sb_t sb_q[$];

    typedef struct {
        logic        mreq_n, rd_n, wr_n, iorq_n;
        logic [15:0] addr;
        logic [7:0]  dout, io_din;
        logic        exp_we;
        logic [9:0]  exp_maddr;
        logic [7:0]  exp_wdata;
        logic        chk_din;
        logic [7:0]  exp_din;
    } vec_t;
    vec_t vecs[11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_cpu(input logic mreq_n, input logic rd_n, input logic wr_n,
                             input logic iorq_n, input logic [15:0] addr, input logic [7:0] dout);
        bus.cpu_mreq_n = mreq_n;
        bus.cpu_rd_n   = rd_n;
        bus.cpu_wr_n   = wr_n;
        bus.cpu_iorq_n = iorq_n;
        bus.cpu_addr   = addr;
        bus.cpu_dout   = dout;
    endtask

    task automatic drive_dma(input logic req, input logic we, input logic [9:0] addr,
                             input logic [7:0] wdata);
        bus.dma_req   = req;
        bus.dma_we    = we;
        bus.dma_addr  = addr;
        bus.dma_wdata = wdata;
    endtask

    // Scoreboard: every dma_ack consumes one expected entry
    always @(negedge clk) begin
        sb_t e;
        if (bus.dma_ack === 1'b1) begin
            n_acks++;
            if (sb_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL dma_ack_unexpected: got ack=1 expected no ack at %0t", $time);
            end else begin
                e = sb_q.pop_front();
                if (e.chk) check("dma_rdata", 32'(bus.dma_rdata), 32'(e.data));
            end
        end
    end

    initial begin
        logic exp_g;
        for (int a = 0; a < 1024; a++) ram[a] = 8'h00;

        vecs[0]  = '{1'b0,1'b1,1'b0,1'b1,16'h0123,8'h5A,8'h00,1'b1,10'h123,8'h5A,1'b0,8'h00};
        vecs[1]  = '{1'b0,1'b0,1'b1,1'b1,16'h0123,8'h00,8'h00,1'b0,10'h123,8'h00,1'b0,8'h00};
        vecs[2]  = '{1'b1,1'b1,1'b1,1'b1,16'h0123,8'h00,8'h00,1'b0,10'h123,8'h00,1'b1,8'h5A};
        vecs[3]  = '{1'b0,1'b1,1'b0,1'b1,16'h83FF,8'h33,8'h00,1'b1,10'h3FF,8'h33,1'b0,8'h00};
        vecs[4]  = '{1'b0,1'b0,1'b1,1'b1,16'h03FF,8'h00,8'h00,1'b0,10'h3FF,8'h00,1'b0,8'h00};
        vecs[5]  = '{1'b1,1'b1,1'b1,1'b1,16'h0000,8'h00,8'h00,1'b0,10'h000,8'h00,1'b1,8'h33};
        vecs[6]  = '{1'b1,1'b0,1'b1,1'b0,16'h0005,8'h00,8'h41,1'b0,10'h005,8'h00,1'b1,8'h41};
        vecs[7]  = '{1'b1,1'b1,1'b0,1'b0,16'h0005,8'h99,8'h41,1'b0,10'h005,8'h99,1'b1,8'h41};
        vecs[8]  = '{1'b0,1'b1,1'b1,1'b1,16'h0005,8'h00,8'h41,1'b0,10'h005,8'h00,1'b0,8'h00};
        vecs[9]  = '{1'b0,1'b0,1'b1,1'b1,16'h0005,8'h00,8'h41,1'b0,10'h005,8'h00,1'b0,8'h00};
        vecs[10] = '{1'b1,1'b1,1'b1,1'b1,16'h0005,8'h00,8'h41,1'b0,10'h005,8'h00,1'b1,8'h00};

        // Reset with busy strobes: outputs must still show reset values
        reset_n = 1'b0;
        bus.io_din = 8'h00;
        drive_cpu(1'b0, 1'b1, 1'b0, 1'b1, 16'h0123, 8'hFF);
        drive_dma(1'b1, 1'b1, 10'h010, 8'hFF);
        for (int i = 0; i < 3; i++) begin
            #2;
            check("rst_dma_gnt", 32'(bus.dma_gnt), 32'd0);
            check("rst_dma_ack", 32'(bus.dma_ack), 32'd0);
            check("rst_cpu_wait_n", 32'(bus.cpu_wait_n), 32'd1);
            check("rst_mem_we", 32'(bus.mem_we), 32'd0);
            check("rst_stat_dma", 32'(bus.stat_dma_cnt), 32'd0);
            check("rst_stat_stall", 32'(bus.stat_stall_cnt), 32'd0);
            step();
        end
        drive_cpu(1'b1, 1'b1, 1'b1, 1'b1, 16'h0000, 8'h00);
        drive_dma(1'b0, 1'b0, 10'h000, 8'h00);
        reset_n = 1'b1;
        step();

        // CPU-only vectors, including address truncation and the I/O mux
        for (int i = 0; i < 11; i++) begin
            drive_cpu(vecs[i].mreq_n, vecs[i].rd_n, vecs[i].wr_n, vecs[i].iorq_n,
                      vecs[i].addr, vecs[i].dout);
            bus.io_din = vecs[i].io_din;
            #2;
            check($sformatf("vec%0d_mem_we", i), 32'(bus.mem_we), 32'(vecs[i].exp_we));
            check($sformatf("vec%0d_mem_addr", i), 32'(bus.mem_addr), 32'(vecs[i].exp_maddr));
            check($sformatf("vec%0d_mem_wdata", i), 32'(bus.mem_wdata), 32'(vecs[i].exp_wdata));
            check($sformatf("vec%0d_cpu_wait_n", i), 32'(bus.cpu_wait_n), 32'd1);
            check($sformatf("vec%0d_dma_gnt", i), 32'(bus.dma_gnt), 32'd0);
            if (vecs[i].chk_din)
                check($sformatf("vec%0d_cpu_din", i), 32'(bus.cpu_din), 32'(vecs[i].exp_din));
            step();
        end

        // DMA in CPU idle gap: write 0xA5 to 0x010, then read it back
        drive_cpu(1'b1, 1'b1, 1'b1, 1'b1, 16'h0000, 8'h00);
        drive_dma(1'b1, 1'b1, 10'h010, 8'hA5);
        #2;
        check("dmaw_gnt", 32'(bus.dma_gnt), 32'd1);
        check("dmaw_mem_we", 32'(bus.mem_we), 32'd1);
        check("dmaw_mem_addr", 32'(bus.mem_addr), 32'h010);
        check("dmaw_mem_wdata", 32'(bus.mem_wdata), 32'hA5);
        check("dmaw_wait_n", 32'(bus.cpu_wait_n), 32'd1);
        sb_q.push_back('{1'b0, 8'h00});
        step();
        drive_dma(1'b1, 1'b0, 10'h010, 8'h00);
        #2;
        check("dmaw_ack", 32'(bus.dma_ack), 32'd1);
        check("ack_ignores_req", 32'(bus.dma_gnt), 32'd0);
        check("ack_mem_we", 32'(bus.mem_we), 32'd0);
        step();
        #2;
        check("dmar_gnt", 32'(bus.dma_gnt), 32'd1);
        check("dmar_mem_we", 32'(bus.mem_we), 32'd0);
        check("dmar_mem_addr", 32'(bus.mem_addr), 32'h010);
        sb_q.push_back('{1'b1, 8'hA5});
        step();
        drive_dma(1'b0, 1'b0, 10'h000, 8'h00);
        #2;
        check("dmar_ack", 32'(bus.dma_ack), 32'd1);
        check("dmar_gnt_in_ack", 32'(bus.dma_gnt), 32'd0);
        step();
        #2;
        check("dmar_ack_done", 32'(bus.dma_ack), 32'd0);
        check("acks_after_gap", 32'(n_acks), 32'd2);

        // Request dropped without grant clears the starvation count
        drive_cpu(1'b0, 1'b0, 1'b1, 1'b1, 16'h0123, 8'h00);
        drive_dma(1'b1, 1'b0, 10'h3FF, 8'h00);
        for (int i = 0; i < 2; i++) begin
            #2;
            check("drop_gnt", 32'(bus.dma_gnt), 32'd0);
            check("drop_wait_n", 32'(bus.cpu_wait_n), 32'd1);
            step();
        end
        drive_dma(1'b0, 1'b0, 10'h3FF, 8'h00);
        #2;
        check("drop_low_gnt", 32'(bus.dma_gnt), 32'd0);
        step();

        // Starvation: CPU busy, forced grant in the 5th requesting cycle
        drive_dma(1'b1, 1'b0, 10'h3FF, 8'h00);
        for (int k = 1; k <= 5; k++) begin
            exp_g = (k == 5);
            #2;
            check($sformatf("starve%0d_gnt", k), 32'(bus.dma_gnt), 32'(exp_g));
            check($sformatf("starve%0d_wait_n", k), 32'(bus.cpu_wait_n), 32'(!exp_g));
            check($sformatf("starve%0d_mem_addr", k), 32'(bus.mem_addr),
                  exp_g ? 32'h3FF : 32'h123);
            if (exp_g) sb_q.push_back('{1'b1, 8'h33});
            step();
        end
        drive_dma(1'b0, 1'b0, 10'h000, 8'h00);
        #2;
        check("starve_ack", 32'(bus.dma_ack), 32'd1);
        check("starve_ack_wait_n", 32'(bus.cpu_wait_n), 32'd1);
        check("starve_ack_mem_addr", 32'(bus.mem_addr), 32'h123);
        check("starve_ack_cpu_din", 32'(bus.cpu_din), 32'h33);
        step();
        drive_cpu(1'b1, 1'b1, 1'b1, 1'b1, 16'h0000, 8'h00);
        #2;
        check("starve_cpu_done_din", 32'(bus.cpu_din), 32'h5A);
        step();
        check("acks_total", 32'(n_acks), 32'd3);
        check("sb_empty", 32'(sb_q.size()), 32'd0);

`ifdef Z80_MEM_ARBITER_STATS_EN
        check("stat_dma_cnt", 32'(bus.stat_dma_cnt), 32'd3);
        check("stat_stall_cnt", 32'(bus.stat_stall_cnt), 32'd1);
`else
        check("stat_dma_cnt", 32'(bus.stat_dma_cnt), 32'd0);
        check("stat_stall_cnt", 32'(bus.stat_stall_cnt), 32'd0);
`endif

        // Reset asserted in the grant cycle abandons the transfer
        drive_dma(1'b1, 1'b1, 10'h020, 8'hEE);
        #2;
        check("rstdma_gnt", 32'(bus.dma_gnt), 32'd1);
        reset_n = 1'b0;
        #1;
        check("rstdma_gnt_low", 32'(bus.dma_gnt), 32'd0);
        check("rstdma_mem_we", 32'(bus.mem_we), 32'd0);
        check("rstdma_wait_n", 32'(bus.cpu_wait_n), 32'd1);
        check("rstdma_stat_dma", 32'(bus.stat_dma_cnt), 32'd0);
        check("rstdma_stat_stall", 32'(bus.stat_stall_cnt), 32'd0);
        step();
        for (int i = 0; i < 2; i++) begin
            #2;
            check("rstdma_hold_ack", 32'(bus.dma_ack), 32'd0);
            check("rstdma_hold_gnt", 32'(bus.dma_gnt), 32'd0);
            step();
        end
        drive_dma(1'b0, 1'b0, 10'h000, 8'h00);
        drive_cpu(1'b0, 1'b0, 1'b1, 1'b1, 16'h0020, 8'h00);
        reset_n = 1'b1;
        #2;
        check("rstdma_after_ack", 32'(bus.dma_ack), 32'd0);
        step();
        drive_cpu(1'b1, 1'b1, 1'b1, 1'b1, 16'h0020, 8'h00);
        #2;
        check("rstdma_no_write", 32'(bus.cpu_din), 32'h00);
        check("rstdma_after_ack2", 32'(bus.dma_ack), 32'd0);
        step();
        check("acks_final", 32'(n_acks), 32'd3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
